// File: rtl/mem_access_unit.sv
// -----------------------------------------------------------------------------
// mem_access_unit
//
// Memory-stage access controller. Takes the EX/MEM bundle, services a load or
// store against a variable-latency data memory over a req/ack handshake, holds
// the upstream pipeline with `stall` while an access is outstanding, and
// presents a registered MEM/WB bundle to writeback (bubbles while stalled).
//
// Parameters
//   ACK_TIMEOUT   max BUSY cycles without mem_ack before the access is
//                 abandoned (2..255)
//
// Ports
//   Clk, Rst                  clock, synchronous active-high reset
//   in_ALU_out                address for loads/stores, result for ALU ops
//   in_ReadData_2             store data
//   in_dest_reg               writeback register number
//   in_MemRead/in_MemWrite    memory-op controls from EX/MEM
//   in_MemToReg/in_RegWrite   writeback controls from EX/MEM
//   mem_req/mem_we/mem_addr/mem_wdata   registered request to data memory
//   mem_ack/mem_rdata         completion and load data from data memory
//   stall                     combinational hold for PC, IF/ID, ID/EX, EX/MEM
//   out_*                     registered MEM/WB bundle
//   out_err_timeout           sticky: an access was abandoned for lack of ack
//   out_err_misaligned        sticky: a memory op had a non-word address
// -----------------------------------------------------------------------------
module mem_access_unit #(
  parameter int ACK_TIMEOUT = 15
) (
  input  logic        Clk,
  input  logic        Rst,
  // EX/MEM bundle
  input  logic [31:0] in_ALU_out,
  input  logic [31:0] in_ReadData_2,
  input  logic [4:0]  in_dest_reg,
  input  logic        in_MemRead,
  input  logic        in_MemWrite,
  input  logic        in_MemToReg,
  input  logic        in_RegWrite,
  // data memory
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  // pipeline hold
  output logic        stall,
  // MEM/WB bundle
  output logic [31:0] out_ALU_out,
  output logic [31:0] out_ReadData,
  output logic [4:0]  out_dest_reg,
  output logic        out_MemToReg,
  output logic        out_RegWrite,
  output logic        out_err_timeout,
  output logic        out_err_misaligned
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  // Counter value at which the last permitted BUSY cycle is reached.
  localparam logic [7:0] LAST_WAIT = 8'(ACK_TIMEOUT - 1);

  state_t      state;
  logic [7:0]  wait_cnt;
  logic [31:0] cap_data;    // load data (or 0) handed to writeback in DONE

  logic mem_op;
  logic misaligned;
  logic start_access;

  assign mem_op       = in_MemRead | in_MemWrite;
  assign misaligned   = (in_ALU_out[1:0] != 2'b00);
  assign start_access = (state == IDLE) && mem_op && !misaligned;

  // Stall covers the IDLE cycle that launches an access plus every BUSY
  // cycle. It is forced low while Rst is high so the reset cycle never holds
  // the pipeline, whatever state the FSM was caught in.
  // NOTE: every signal assigned in always_comb gets a default first, so no
  // path can leave it unassigned and infer a latch.
  always_comb begin
    stall = 1'b0;
    if (!Rst) begin
      stall = start_access || (state == BUSY);
    end
  end

  // NOTE: sequential state is written with non-blocking assignments only, so
  // every register samples the pre-edge values of the others.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      // NOTE: this block holds only flops (no memory arrays), so every
      // register is reset; a Rst during BUSY/DONE simply abandons the access.
      state              <= IDLE;
      wait_cnt           <= 8'd0;
      cap_data           <= 32'd0;
      mem_req            <= 1'b0;
      mem_we             <= 1'b0;
      mem_addr           <= 32'd0;
      mem_wdata          <= 32'd0;
      out_ALU_out        <= 32'd0;
      out_ReadData       <= 32'd0;
      out_dest_reg       <= 5'd0;
      out_MemToReg       <= 1'b0;
      out_RegWrite       <= 1'b0;
      out_err_timeout    <= 1'b0;
      out_err_misaligned <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (!mem_op) begin
            // Plain ALU op: straight through in one cycle.
            out_ALU_out  <= in_ALU_out;
            out_dest_reg <= in_dest_reg;
            out_MemToReg <= in_MemToReg;
            out_RegWrite <= in_RegWrite;
            out_ReadData <= 32'd0;
          end else if (misaligned) begin
            // Misaligned access is dropped: no request, and writeback is
            // suppressed so no register picks up a bogus value.
            out_ALU_out        <= in_ALU_out;
            out_dest_reg       <= in_dest_reg;
            out_MemToReg       <= 1'b0;
            out_RegWrite       <= 1'b0;
            out_ReadData       <= 32'd0;
            out_err_misaligned <= 1'b1;
          end else begin
            // Launch the access. Address/data/direction are captured here and
            // not touched again until the next launch, so they stay stable
            // for the whole time mem_req is high. Both MemRead and MemWrite
            // high is treated as a write.
            mem_addr     <= in_ALU_out;
            mem_wdata    <= in_ReadData_2;
            mem_we       <= in_MemWrite;
            mem_req      <= 1'b1;
            wait_cnt     <= 8'd0;
            out_RegWrite <= 1'b0;
            state        <= BUSY;
          end
        end

        BUSY: begin
          out_RegWrite <= 1'b0;  // bubble to writeback while waiting
          if (mem_ack) begin
            // Writes return no data; stores never forward mem_rdata.
            cap_data <= mem_we ? 32'd0 : mem_rdata;
            mem_req  <= 1'b0;
            state    <= DONE;
          end else if (wait_cnt == LAST_WAIT) begin
            cap_data        <= 32'd0;
            out_err_timeout <= 1'b1;
            mem_req         <= 1'b0;
            state           <= DONE;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end

        DONE: begin
          // Upstream has held the EX/MEM bundle stable, so it is still valid.
          out_ALU_out  <= in_ALU_out;
          out_dest_reg <= in_dest_reg;
          out_MemToReg <= in_MemToReg;
          out_RegWrite <= in_RegWrite;
          out_ReadData <= cap_data;
          state        <= IDLE;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// -----------------------------------------------------------------------------
// tb_mem_access_unit
//
// Self-checking bench: a table of directed vectors (the documented corner
// cases), a randomized phase checked against a transaction-level model, and a
// hand-written reset-during-BUSY sequence. The bench plays the data memory,
// acking each request after a chosen number of request cycles.
// -----------------------------------------------------------------------------
module tb_mem_access_unit;

  localparam int T = 15;  // ACK_TIMEOUT

  logic        Clk = 1'b0;
  logic        Rst;
  logic [31:0] in_ALU_out, in_ReadData_2;
  logic [4:0]  in_dest_reg;
  logic        in_MemRead, in_MemWrite, in_MemToReg, in_RegWrite;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        stall;
  logic [31:0] out_ALU_out, out_ReadData;
  logic [4:0]  out_dest_reg;
  logic        out_MemToReg, out_RegWrite, out_err_timeout, out_err_misaligned;

  always #5 Clk = ~Clk;

  mem_access_unit #(.ACK_TIMEOUT(T)) dut (
    .Clk               (Clk),
    .Rst               (Rst),
    .in_ALU_out        (in_ALU_out),
    .in_ReadData_2     (in_ReadData_2),
    .in_dest_reg       (in_dest_reg),
    .in_MemRead        (in_MemRead),
    .in_MemWrite       (in_MemWrite),
    .in_MemToReg       (in_MemToReg),
    .in_RegWrite       (in_RegWrite),
    .mem_req           (mem_req),
    .mem_we            (mem_we),
    .mem_addr          (mem_addr),
    .mem_wdata         (mem_wdata),
    .mem_ack           (mem_ack),
    .mem_rdata         (mem_rdata),
    .stall             (stall),
    .out_ALU_out       (out_ALU_out),
    .out_ReadData      (out_ReadData),
    .out_dest_reg      (out_dest_reg),
    .out_MemToReg      (out_MemToReg),
    .out_RegWrite      (out_RegWrite),
    .out_err_timeout   (out_err_timeout),
    .out_err_misaligned(out_err_misaligned)
  );

  // One EX/MEM instruction plus how the memory will respond to it.
  // lat = request cycle in which mem_ack is given; 0 or >T means never.
  typedef struct {
    logic [31:0] alu;
    logic [31:0] rd2;
    logic [31:0] rdata;
    logic [4:0]  dest;
    logic        mr, mw, m2r, rw;
    int          lat;
  } op_t;

  // What one instruction looks like from outside once it has retired.
  typedef struct {
    int          stall_cyc;
    int          req_cyc;
    logic [31:0] read_data;
    logic        rw, m2r, err_mis, err_to;
  } res_t;

  typedef struct {
    op_t  op;
    res_t exp;
  } vec_t;

  int n_checks = 0;
  int n_pass   = 0;

  // Sticky error state of the reference model.
  bit m_err_mis = 1'b0;
  bit m_err_to  = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, required 0x%08h", name, act, exp);
  endtask

  function automatic op_t mkop(input logic [31:0] alu, input logic [31:0] rd2,
                               input logic [4:0] dest, input logic mr, input logic mw,
                               input logic m2r, input logic rw, input int lat,
                               input logic [31:0] rdata);
    op_t o;
    o.alu = alu; o.rd2 = rd2; o.dest = dest; o.mr = mr; o.mw = mw;
    o.m2r = m2r; o.rw = rw; o.lat = lat; o.rdata = rdata;
    return o;
  endfunction

  function automatic res_t mkres(input int st, input int rq, input logic [31:0] rd,
                                 input logic rw, input logic m2r, input logic em,
                                 input logic et);
    res_t r;
    r.stall_cyc = st; r.req_cyc = rq; r.read_data = rd;
    r.rw = rw; r.m2r = m2r; r.err_mis = em; r.err_to = et;
    return r;
  endfunction

  // Transaction-level reference: what the retired instruction must look like.
  function automatic res_t model(input op_t op);
    res_t r;
    bit   memop;
    bit   timed_out;
    int   waits;
    memop       = op.mr | op.mw;
    r.stall_cyc = 0;
    r.req_cyc   = 0;
    r.read_data = 32'd0;
    r.rw        = op.rw;
    r.m2r       = op.m2r;
    if (memop && op.alu[1:0] != 2'b00) begin
      r.rw      = 1'b0;
      r.m2r     = 1'b0;
      m_err_mis = 1'b1;
    end else if (memop) begin
      timed_out   = (op.lat < 1) || (op.lat > T);
      waits       = timed_out ? T : op.lat;
      r.req_cyc   = waits;
      r.stall_cyc = waits + 1;
      if (timed_out) m_err_to = 1'b1;
      else if (!op.mw) r.read_data = op.rdata;
    end
    r.err_mis = m_err_mis;
    r.err_to  = m_err_to;
    return r;
  endfunction

  task automatic drive_inputs(input op_t op);
    in_ALU_out    = op.alu;
    in_ReadData_2 = op.rd2;
    in_dest_reg   = op.dest;
    in_MemRead    = op.mr;
    in_MemWrite   = op.mw;
    in_MemToReg   = op.m2r;
    in_RegWrite   = op.rw;
  endtask

  // Called just after a rising edge. Holds the instruction while stalled,
  // acts as the memory, and returns once the instruction has retired.
  task automatic run_op(input string tag, input op_t op, output res_t obs);
    bit fin;
    int c;
    fin = 1'b0;
    c   = 0;
    obs.stall_cyc = 0;
    obs.req_cyc   = 0;
    drive_inputs(op);
    while (!fin && c < 64) begin
      if (mem_req) begin
        obs.req_cyc++;
        check({tag, ".mem_addr"},  mem_addr,  op.alu);
        check({tag, ".mem_we"},    32'(mem_we), 32'(op.mw));
        check({tag, ".mem_wdata"}, mem_wdata, op.rd2);
        mem_ack   = (obs.req_cyc == op.lat);
        mem_rdata = mem_ack ? op.rdata : $urandom;
      end else begin
        // Acks with no request outstanding must be ignored.
        mem_ack   = 1'($urandom_range(0, 1));
        mem_rdata = $urandom;
      end
      @(negedge Clk);
      if (stall) begin
        obs.stall_cyc++;
        if (c > 0) check({tag, ".bubble_RegWrite"}, 32'(out_RegWrite), 32'd0);
      end else begin
        fin = 1'b1;
      end
      @(posedge Clk);
      #1;
      c++;
    end
    if (!fin) check({tag, ".retire_within_budget"}, 32'd0, 32'd1);
    mem_ack = 1'b0;
    check({tag, ".out_ALU_out"},  out_ALU_out,        op.alu);
    check({tag, ".out_dest_reg"}, 32'(out_dest_reg), 32'(op.dest));
    obs.read_data = out_ReadData;
    obs.rw        = out_RegWrite;
    obs.m2r       = out_MemToReg;
    obs.err_mis   = out_err_misaligned;
    obs.err_to    = out_err_timeout;
  endtask

  task automatic compare(input string tag, input res_t obs, input res_t exp);
    check({tag, ".stall_cycles"}, 32'(obs.stall_cyc), 32'(exp.stall_cyc));
    check({tag, ".req_cycles"},   32'(obs.req_cyc),   32'(exp.req_cyc));
    check({tag, ".out_ReadData"}, obs.read_data,      exp.read_data);
    check({tag, ".out_RegWrite"}, 32'(obs.rw),        32'(exp.rw));
    check({tag, ".out_MemToReg"}, 32'(obs.m2r),       32'(exp.m2r));
    check({tag, ".err_misaligned"}, 32'(obs.err_mis), 32'(exp.err_mis));
    check({tag, ".err_timeout"},  32'(obs.err_to),    32'(exp.err_to));
  endtask

  // Two reset edges with garbage (including an aligned memory op) on inputs.
  task automatic apply_reset(input string tag);
    Rst           = 1'b1;
    in_ALU_out    = 32'hA5A5_0000;
    in_ReadData_2 = $urandom;
    in_dest_reg   = 5'd17;
    in_MemRead    = 1'b1;
    in_MemWrite   = 1'b0;
    in_MemToReg   = 1'b1;
    in_RegWrite   = 1'b1;
    mem_ack       = 1'b1;
    mem_rdata     = $urandom;
    repeat (2) @(posedge Clk);
    @(negedge Clk);
    check({tag, ".stall"},        32'(stall),        32'd0);
    check({tag, ".mem_req"},      32'(mem_req),      32'd0);
    check({tag, ".mem_we"},       32'(mem_we),       32'd0);
    check({tag, ".mem_addr"},     mem_addr,          32'd0);
    check({tag, ".mem_wdata"},    mem_wdata,         32'd0);
    check({tag, ".out_ALU_out"},  out_ALU_out,       32'd0);
    check({tag, ".out_ReadData"}, out_ReadData,      32'd0);
    check({tag, ".out_dest_reg"}, 32'(out_dest_reg), 32'd0);
    check({tag, ".out_MemToReg"}, 32'(out_MemToReg), 32'd0);
    check({tag, ".out_RegWrite"}, 32'(out_RegWrite), 32'd0);
    check({tag, ".err_timeout"},  32'(out_err_timeout),    32'd0);
    check({tag, ".err_misaligned"}, 32'(out_err_misaligned), 32'd0);
    @(posedge Clk);
    #1;
    Rst     = 1'b0;
    mem_ack = 1'b0;
    m_err_mis = 1'b0;
    m_err_to  = 1'b0;
  endtask

  vec_t vecs[9];
  res_t obs;
  res_t exp;
  op_t  op;

  initial begin
    // Directed vectors, in order; error flags accumulate down the table.
    vecs[0] = '{op: mkop(32'h0000_1234, 32'h0,         5'd8,  0, 0, 0, 1, 0,  32'h0),
                exp: mkres(0,  0,  32'h0,         1, 0, 0, 0)};
    vecs[1] = '{op: mkop(32'h0000_0040, 32'h0,         5'd5,  1, 0, 1, 1, 3,  32'hDEAD_BEEF),
                exp: mkres(4,  3,  32'hDEAD_BEEF, 1, 1, 0, 0)};
    vecs[2] = '{op: mkop(32'h0000_0044, 32'h55AA_55AA, 5'd0,  0, 1, 0, 0, 1,  32'h1357_9BDF),
                exp: mkres(2,  1,  32'h0,         0, 0, 0, 0)};
    vecs[3] = '{op: mkop(32'h0000_0048, 32'h1111_1111, 5'd3,  1, 1, 1, 1, 2,  32'hCAFE_F00D),
                exp: mkres(3,  2,  32'h0,         1, 1, 0, 0)};
    vecs[4] = '{op: mkop(32'h0000_004C, 32'h0,         5'd9,  1, 0, 1, 1, 15, 32'h0BAD_F00D),
                exp: mkres(16, 15, 32'h0BAD_F00D, 1, 1, 0, 0)};
    vecs[5] = '{op: mkop(32'h0000_0042, 32'h0,         5'd4,  1, 0, 1, 1, 1,  32'h2222_2222),
                exp: mkres(0,  0,  32'h0,         0, 0, 1, 0)};
    vecs[6] = '{op: mkop(32'h0000_0041, 32'h7777_7777, 5'd0,  0, 1, 0, 0, 1,  32'h0),
                exp: mkres(0,  0,  32'h0,         0, 0, 1, 0)};
    vecs[7] = '{op: mkop(32'h0000_0080, 32'h0,         5'd6,  1, 0, 1, 1, 0,  32'h3333_3333),
                exp: mkres(16, 15, 32'h0,         1, 1, 1, 1)};
    vecs[8] = '{op: mkop(32'hFFFF_FFFF, 32'h0,         5'd31, 0, 0, 0, 1, 0,  32'h0),
                exp: mkres(0,  0,  32'h0,         1, 0, 1, 1)};

    apply_reset("reset");

    for (int i = 0; i < 9; i++) begin
      run_op($sformatf("vec%0d", i), vecs[i].op, obs);
      compare($sformatf("vec%0d", i), obs, vecs[i].exp);
    end

    // Randomized phase against the transaction-level model.
    apply_reset("reset2");
    for (int i = 0; i < 80; i++) begin
      int kind;
      kind     = $urandom_range(0, 3);
      op.alu   = $urandom;
      op.rd2   = $urandom;
      op.rdata = $urandom;
      op.dest  = 5'($urandom);
      op.m2r   = 1'($urandom_range(0, 1));
      op.rw    = 1'($urandom_range(0, 1));
      op.lat   = $urandom_range(1, T + 2);
      case (kind)
        0: begin op.mr = 1'b0; op.mw = 1'b0; end
        1: begin op.mr = 1'b1; op.mw = 1'($urandom_range(0, 3) == 0); op.alu[1:0] = 2'b00; end
        2: begin op.mr = 1'b0; op.mw = 1'b1; op.alu[1:0] = 2'b00; end
        default: begin
          op.mr = 1'($urandom_range(0, 1));
          op.mw = ~op.mr;
          op.alu[1:0] = 2'($urandom_range(1, 3));
        end
      endcase
      exp = model(op);
      run_op($sformatf("rnd%0d", i), op, obs);
      compare($sformatf("rnd%0d", i), obs, exp);
    end

    // Reset in the 2nd BUSY cycle aborts the access; a late ack is ignored.
    op  = mkop(32'h0000_0003, 32'h0, 5'd2, 1, 0, 1, 1, 0, 32'h0);
    exp = model(op);  // misaligned: makes sure a flag is set before the reset
    run_op("pre_abort", op, obs);
    compare("pre_abort", obs, exp);
    drive_inputs(mkop(32'h0000_0100, 32'h0, 5'd7, 1, 0, 1, 1, 0, 32'h0));
    mem_ack = 1'b0;
    @(posedge Clk); #1;  // BUSY cycle 1
    check("abort.mem_req_busy1", 32'(mem_req), 32'd1);
    @(posedge Clk); #1;  // BUSY cycle 2
    Rst = 1'b1;
    @(negedge Clk);
    check("abort.stall_in_reset", 32'(stall), 32'd0);
    @(posedge Clk); #1;
    Rst = 1'b0;
    drive_inputs(mkop(32'h0000_0ABC, 32'h0, 5'd12, 0, 0, 0, 1, 0, 32'h0));
    mem_ack   = 1'b1;
    mem_rdata = 32'h1234_5678;
    check("abort.mem_req_after", 32'(mem_req), 32'd0);
    check("abort.err_misaligned", 32'(out_err_misaligned), 32'd0);
    check("abort.err_timeout", 32'(out_err_timeout), 32'd0);
    @(negedge Clk);
    check("abort.stall_idle", 32'(stall), 32'd0);
    @(posedge Clk); #1;
    mem_ack = 1'b0;
    check("abort.late_ack_req", 32'(mem_req), 32'd0);
    check("abort.out_ReadData", out_ReadData, 32'd0);
    check("abort.out_ALU_out", out_ALU_out, 32'h0000_0ABC);
    check("abort.out_RegWrite", 32'(out_RegWrite), 32'd1);
    m_err_mis = 1'b0;
    m_err_to  = 1'b0;
    op  = mkop(32'h0000_0200, 32'h0, 5'd14, 1, 0, 1, 1, 2, 32'hFEED_FACE);
    exp = model(op);
    run_op("post_abort", op, obs);
    compare("post_abort", obs, exp);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Memory-stage access controller that consumes the EX/MEM stage outputs (address, store data, control bits, destination register) and services the load/store against a variable-latency data memory using a req/ack handshake. It stalls the upstream pipeline while an access is outstanding and presents a registered MEM/WB bundle (ALU result, load data, destination, writeback controls) to the writeback stage, inserting bubbles while stalled.

## Interface
- ACK_TIMEOUT, 15: max BUSY cycles without mem_ack before abandoning the access (range 2..255).

- Clk  input  1  clock; all state updates on posedge Clk.
- Rst  input  1  reset, synchronous, active-high.
- in_ALU_out  input  32  address for loads/stores; result for ALU ops.
- in_ReadData_2  input  32  store data.
- in_dest_reg  input  5  writeback register number.
- in_MemRead, in_MemWrite, in_MemToReg, in_RegWrite  input  1 each  control bits from EX/MEM.
- mem_req  output  1  request to data memory, registered.
- mem_we  output  1  1 = write, registered.
- mem_addr  output  32  word address, registered.
- mem_wdata  output  32  write data, registered.
- mem_ack  input  1  memory completion, sampled only in BUSY.
- mem_rdata  input  32  load data, valid with mem_ack.
- stall  output  1  combinational; holds PC, IF/ID, ID/EX, EX/MEM.
- out_ALU_out  output  32  registered.
- out_ReadData  output  32  registered load data.
- out_dest_reg  output  5  registered.
- out_MemToReg, out_RegWrite  output  1 each  registered.
- out_err_timeout, out_err_misaligned  output  1 each  sticky error flags.

## Operation
- Memory op = in_MemRead | in_MemWrite. Both high: treated as write (mem_we=1), out_ReadData=0.
- States: IDLE, BUSY, DONE. 8-bit wait counter, cleared on entry to BUSY.
- IDLE, no memory op: stall=0; at edge out_* load in_* fields, out_ReadData=0.
- IDLE, memory op, in_ALU_out[1:0]!=0 (misaligned): no request, stall=0; at edge out_* load in_* but out_RegWrite=0, out_MemToReg=0; out_err_misaligned<=1.
- IDLE, aligned memory op: stall=1; at edge latch mem_addr=in_ALU_out, mem_wdata=in_ReadData_2, mem_we=in_MemWrite, mem_req<=1, -> BUSY; out_RegWrite<=0 (bubble).
- BUSY: stall=1, mem_req=1. mem_ack=1: capture mem_rdata (0 for writes), mem_req<=0, -> DONE. No ack and counter==ACK_TIMEOUT-1: captured data=0, out_err_timeout<=1, mem_req<=0, -> DONE. Else counter++. Every BUSY edge writes out_RegWrite=0.
- DONE: stall=0, mem_req=0; at edge out_* load in_* fields (still held stable), out_ReadData=captured data; -> IDLE.
- mem_ack outside BUSY ignored; mem_rdata only sampled on ack.
- Error flags sticky; cleared only by Rst.

## Timing
- Reset: state IDLE, counter 0, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, all out_* =0, both error flags 0. stall=0 in the reset cycle. Rst in BUSY/DONE aborts access: mem_req low the cycle after Rst edge.
- Non-memory op: one-cycle latency in->out, no stall.
- Aligned access with ack in the k-th BUSY cycle (k>=1): stall high k+1 cycles (IDLE cycle + k BUSY cycles); outputs valid 1 cycle after DONE; total in->out latency k+2.
- Timeout: stall high ACK_TIMEOUT+1 cycles.
- Back-to-back memory ops: DONE -> IDLE -> BUSY; no overlap, at most one outstanding request.
- mem_addr/mem_wdata/mem_we stable for the whole time mem_req=1.

## Test plan
- Reset: assert Rst 2 cycles with garbage inputs -> all outputs 0, stall=0, mem_req=0.
- ALU op: in_ALU_out=0x0000_1234, in_dest_reg=8, RegWrite=1 -> next edge out_ALU_out=0x1234, out_dest_reg=8, out_RegWrite=1, stall never high.
- Load, ack in 3rd BUSY cycle, mem_rdata=0xDEAD_BEEF, addr 0x40 -> mem_req high 3 cycles with mem_addr=0x40, mem_we=0; stall high 4 cycles; out_RegWrite=0 during stall, then out_ReadData=0xDEADBEEF, out_MemToReg=1, out_RegWrite=1.
- Store to 0x44 data 0x55AA_55AA, immediate ack -> mem_we=1, mem_wdata=0x55AA55AA for 1 cycle, stall 2 cycles, out_RegWrite=0.
- Misaligned load addr 0x42 -> no mem_req, no stall, out_err_misaligned=1, out_RegWrite=0; followed by timeout load (mem_ack never) -> stall 16 cycles, out_ReadData=0, out_err_timeout=1.
- Rst asserted in 2nd BUSY cycle -> mem_req=0 next cycle, state IDLE, errors cleared; late mem_ack ignored.
